non_res_div_seq: RTL and testbench

//  Sequential, parametrised non-restoring integer divider: one quotient bit per clock.

---
 rtl/non_res_div_pkg.sv | 26 ++
 rtl/non_res_div_step.sv | 25 ++
 rtl/non_res_div_seq.sv | 161 ++++++++++++++++
 tb/tb_non_res_div_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/non_res_div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   div_state_t : FSM state encoding (ST_IDLE, ST_DIVIDE, ST_CORRECT, ST_FINISH)
//   abs_val     : two's-complement magnitude of the low w bits of x. The result
//                 is returned as an unsigned value, so the magnitude of MIN
//                 (e.g. 0x80 for w=8) is representable.
package non_res_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_CORRECT = 2'd2,
        ST_FINISH  = 2'd3
    } div_state_t;

    localparam int ABS_MAX_W = 64;

    function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x,
                                                     input int                   w);
        logic [ABS_MAX_W-1:0] mask;
        logic                 neg;
        mask = (w >= ABS_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        neg  = ((x >> (w - 1)) & 64'd1) != 64'd0;
        abs_val = neg ? ((~x + 64'd1) & mask) : (x & mask);
    endfunction

endpackage

// File: rtl/non_res_div_step.sv
// One combinational non-restoring iteration.
//   i_a : partial remainder, WIDTH+1 bits, MSB is its sign
//   i_q : quotient/dividend shift register
//   i_d : divisor magnitude
//   o_a : next partial remainder
//   o_q : next quotient shift register (new quotient bit in LSB)
module non_res_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH:0] w_shift;

    // The shifted value may overflow WIDTH+1 bits, but the result after the
    // add/subtract always lies in [-D, D), so modular arithmetic gives the
    // exact value. The add/subtract decision uses the pre-shift sign.
    assign w_shift = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    assign o_a     = i_a[WIDTH] ? (w_shift + {1'b0, i_d}) : (w_shift - {1'b0, i_d});
    assign o_q     = {i_q[WIDTH-2:0], ~o_a[WIDTH]};

endmodule

// File: rtl/non_res_div_seq.sv
// Sequential non-restoring divider, one quotient bit per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, signed_op     : request (taken when busy=0) and signed-mode select
//   dividend, divisor    : operands, sampled on the accepting edge
//   busy                 : operation in progress, start ignored
//   done                 : one-cycle pulse, results valid from this cycle
//   quotient, remainder  : results, held until the next op's done
//   div_by_zero          : divisor was zero, held with the results
// done appears WIDTH+2 clock edges after the accepting edge for every operand.
module non_res_div_seq
    import non_res_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_dvd_raw;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dvs_zero;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_a_step;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_last_iter;

    assign w_dvd_neg   = signed_op & dividend[WIDTH-1];
    assign w_dvs_neg   = signed_op & divisor[WIDTH-1];
    assign w_dvd_mag   = signed_op ? WIDTH'(abs_val(ABS_MAX_W'(dividend), WIDTH)) : dividend;
    assign w_dvs_mag   = signed_op ? WIDTH'(abs_val(ABS_MAX_W'(divisor), WIDTH)) : divisor;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // Truncating division: quotient sign is the XOR of operand signs, remainder
    // follows the dividend. MIN / -1 falls out naturally as quotient MIN.
    assign w_quot_fix  = r_q_neg ? -r_q : r_q;
    assign w_rem_fix   = r_r_neg ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];

    non_res_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_d (r_d),
        .o_a (w_a_step),
        .o_q (w_q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = ST_DIVIDE;
            ST_DIVIDE:  if (w_last_iter) w_state_next = ST_CORRECT;
            ST_CORRECT: w_state_next = ST_FINISH;
            ST_FINISH:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // FINISH publishes the results on its exit edge, so the done cycle is
    // spent back in IDLE with busy low; a start seen there is accepted at the
    // end of the done cycle, giving gapless back-to-back issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_q        <= '0;
            r_d        <= '0;
            r_dvd_raw  <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dvs_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a        <= '0;
                        r_q        <= w_dvd_mag;
                        r_d        <= w_dvs_mag;
                        r_dvd_raw  <= dividend;
                        r_cnt      <= '0;
                        r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg    <= w_dvd_neg;
                        r_dvs_zero <= (divisor == '0);
                        r_busy     <= 1'b1;
                    end
                end
                ST_DIVIDE: begin
                    r_a   <= w_a_step;
                    r_q   <= w_q_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_CORRECT: begin
                    if (r_a[WIDTH]) r_a <= r_a + {1'b0, r_d};
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_dvs_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_dvd_raw;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_non_res_div_seq.sv
// Scoreboard bench for non_res_div_seq (WIDTH=8).
module tb_non_res_div_seq;
    localparam int W       = 8;
    localparam int LATENCY = W + 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend  = '0;
    logic [W-1:0] divisor   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sg;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           issue_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         m_e;
    int           n_checks  = 0;
    int           n_fail    = 0;
    int           cyc       = 0;
    int           n_ops     = 0;
    logic [W-1:0] last_q    = '0;
    logic [W-1:0] last_r    = '0;
    logic         prev_done = 1'b0;

    non_res_div_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, truncating toward zero.
    function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sg);
        exp_t e;
        int   a;
        int   b;
        e.dvd = dvd;
        e.dvs = dvs;
        e.sg  = sg;
        e.issue_cyc = 0;
        if (dvs == '0) begin
            e.q   = '1;
            e.r   = dvd;
            e.dbz = 1'b1;
        end else begin
            if (sg) begin
                a = int'($signed(dvd));
                b = int'($signed(dvs));
            end else begin
                a = int'(dvd);
                b = int'(dvs);
            end
            e.q   = W'(a / b);
            e.r   = W'(a % b);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            check_val("done_single", 32'(prev_done), 32'd0);
            check_val("busy_at_done", 32'(busy), 32'd0);
            check_val("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                n_ops++;
                $display("op %0d %s %02h/%02h -> q=%02h r=%02h dbz=%0b lat=%0d",
                         n_ops, m_e.sg ? "S" : "U", m_e.dvd, m_e.dvs,
                         quotient, remainder, div_by_zero, cyc - m_e.issue_cyc);
                check_val("quotient", 32'(quotient), 32'(m_e.q));
                check_val("remainder", 32'(remainder), 32'(m_e.r));
                check_val("div_by_zero", 32'(div_by_zero), 32'(m_e.dbz));
                check_val("latency", 32'(cyc - m_e.issue_cyc), 32'(LATENCY));
                last_q = m_e.q;
                last_r = m_e.r;
            end
        end
        prev_done = done;
    end

    task automatic wait_not_busy();
        int g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (busy) check_val("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sg, input bit track);
        exp_t e;
        wait_not_busy();
        start     = 1'b1;
        dividend  = dvd;
        divisor   = dvs;
        signed_op = sg;
        if (track) begin
            e = model(dvd, dvs, sg);
            e.issue_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        signed_op = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        check_val("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            3:       return 8'h01;
            4:       return 8'h7F;
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0] dir_dvd [8] = '{8'd200, 8'hF9, 8'h07, 8'h55, 8'h55, 8'h80, 8'h80, 8'hFF};
    logic [W-1:0] dir_dvs [8] = '{8'd7,   8'h02, 8'hFE, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01};
    logic         dir_sg  [8] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

    initial begin
        exp_t e;
        int   g;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_q", 32'(quotient), 32'd0);
        check_val("rst_r", 32'(remainder), 32'd0);
        check_val("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, each followed by a hold check
        for (int i = 0; i < 8; i++) begin
            issue(dir_dvd[i], dir_dvs[i], dir_sg[i], 1'b1);
            drain();
            repeat (3) @(negedge clk);
            check_val("hold_q", 32'(quotient), 32'(last_q));
            check_val("hold_r", 32'(remainder), 32'(last_r));
        end

        // Start pulsed mid-operation must be ignored
        issue(8'd100, 8'd9, 1'b0, 1'b1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd1;
        check_val("busy_mid_op", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        check_val("no_extra_op", 32'(busy), 32'd0);

        // Start held high through done: second op accepted in the done cycle
        wait_not_busy();
        start     = 1'b1;
        dividend  = 8'd123;
        divisor   = 8'd10;
        signed_op = 1'b0;
        e = model(8'd123, 8'd10, 1'b0);
        e.issue_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        dividend  = 8'hF0;
        divisor   = 8'h03;
        signed_op = 1'b1;
        g = 0;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        check_val("b2b_done_seen", 32'(done), 32'd1);
        e = model(8'hF0, 8'h03, 1'b1);
        e.issue_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of an op
        issue(8'd77, 8'd5, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_q", 32'(quotient), 32'd0);
        check_val("arst_r", 32'(remainder), 32'd0);
        check_val("arst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("arst_idle", 32'(busy), 32'd0);
        issue(8'd77, 8'd5, 1'b0, 1'b1);
        drain();

        // Randomised sweep, back-to-back issue
        for (int i = 0; i < 3000; i++) begin
            issue(pick(), pick(), 1'($urandom), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
